// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing generator, gated by a synchronized PLL lock flag.
// Optional colour-bar test pattern on rgb when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       frame_start
`ifdef VGA_TEST_PATTERN_EN
  , output logic [11:0] rgb
`endif
);

  // H_TOTAL and V_TOTAL must each fit the 10-bit counters (<= 1024).
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  // Decode bounds are 11 bits so a sync window ending exactly at 1024 still works.
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {WAIT_LOCK = 1'b0, RUN = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [1:0]  lock_sync;
  logic        lock_s;
  logic [9:0]  h_cnt, v_cnt, h_nxt, v_nxt;
  logic        run_nxt;
  logic [10:0] hx, vx;
  logic        hs_on, vs_on, von_nxt, fs_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lock_sync <= '0;
    else      lock_sync <= {lock_sync[0], locked};
  end
  assign lock_s = lock_sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= WAIT_LOCK;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      state <= state_nxt;
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  // Next-state and next-count; lock loss abandons the frame immediately.
  always_comb begin
    state_nxt = state;
    h_nxt     = '0;
    v_nxt     = '0;
    run_nxt   = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = RUN;
          run_nxt   = 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
        end else begin
          run_nxt = 1'b1;
          h_nxt   = (h_cnt == H_LAST) ? '0 : h_cnt + 10'd1;
          v_nxt   = v_cnt;
          if (h_cnt == H_LAST) v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  // Decode next counts so registered outputs line up with the counters.
  assign hx      = {1'b0, h_nxt};
  assign vx      = {1'b0, v_nxt};
  assign hs_on   = run_nxt && (hx >= HS_BEG) && (hx < HS_END);
  assign vs_on   = run_nxt && (vx >= VS_BEG) && (vx < VS_END);
  assign von_nxt = run_nxt && (hx < H_ACT) && (vx < V_ACT);
  assign fs_nxt  = run_nxt && (h_nxt == '0) && (v_nxt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hs_on ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_on ? SYNC_POL : ~SYNC_POL;
      video_on    <= von_nxt;
      pix_x       <= von_nxt ? h_nxt : '0;
      pix_y       <= von_nxt ? v_nxt : '0;
      frame_start <= fs_nxt;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  // Eight 80-px bars: x[9:4] counts 16-px groups, five groups per bar.
  logic [5:0]  bar;
  logic [11:0] rgb_nxt;
  assign bar = h_nxt[9:4] / 6'd5;

  always_comb begin
    rgb_nxt = '0;
    if (von_nxt) begin
      case (bar)
        6'd0:    rgb_nxt = 12'hFFF;
        6'd1:    rgb_nxt = 12'hFF0;
        6'd2:    rgb_nxt = 12'h0FF;
        6'd3:    rgb_nxt = 12'h0F0;
        6'd4:    rgb_nxt = 12'hF0F;
        6'd5:    rgb_nxt = 12'hF00;
        6'd6:    rgb_nxt = 12'h00F;
        default: rgb_nxt = 12'h000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rgb <= '0;
    else      rgb <= rgb_nxt;
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: real horizontal timing, shortened vertical
// timing (15 lines) so full frames fit a short run.
module tb_vga_timing_gen;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 8,   VF = 2,  VS = 2,  VB = 3;
  localparam int HT = HA + HF + HS + HB;   // 800
  localparam int VT = VA + VF + VS + VB;   // 15
  localparam int FRAME = HT * VT;          // 12000

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       von;
    logic [9:0] x;
    logic [9:0] y;
    logic       fs;
  } smp_t;

  localparam smp_t IDLE = '{hs: 1'b1, vs: 1'b1, von: 1'b0, x: 10'd0, y: 10'd0, fs: 1'b0};

  logic clk = 1'b0, rst = 1'b0, locked = 1'b0;
  logic hsync, vsync, video_on, frame_start;
  logic [9:0] pix_x, pix_y;
`ifdef VGA_TEST_PATTERN_EN
  logic [11:0] rgb;
`endif

  int n_cmp = 0, n_err = 0;
  smp_t exp_q[$];

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .locked(locked),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start)
`ifdef VGA_TEST_PATTERN_EN
    , .rgb(rgb)
`endif
  );

  always #20 clk = ~clk;

  function automatic smp_t dut_smp();
    smp_t s;
    s = '{hs: hsync, vs: vsync, von: video_on, x: pix_x, y: pix_y, fs: frame_start};
    return s;
  endfunction

  // Reference raster point straight from the timing definition (active-low syncs).
  function automatic smp_t model(input int h, input int v);
    smp_t s;
    s.hs  = !((h >= HA + HF) && (h < HA + HF + HS));
    s.vs  = !((v >= VA + VF) && (v < VA + VF + VS));
    s.von = (h < HA) && (v < VA);
    s.x   = s.von ? 10'(h) : 10'd0;
    s.y   = s.von ? 10'(v) : 10'd0;
    s.fs  = (h == 0) && (v == 0);
    return s;
  endfunction

  task automatic test_reset();
    smp_t e, obs;
    rst = 1'b0; locked = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    exp_q.push_back(IDLE);
    e = exp_q.pop_front(); obs = dut_smp();
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL reset_state: got %h expected %h", obs, e); end
`ifdef VGA_TEST_PATTERN_EN
    n_cmp++;
    if (rgb !== 12'h000) begin n_err++; $display("FAIL reset_rgb: got %h expected 000", rgb); end
`endif
  endtask

  // Released at a negedge: two sync stages, then the (0,0) point on the third edge.
  task automatic test_startup();
    smp_t e, obs;
    rst = 1'b1;
    exp_q.push_back(IDLE);
    exp_q.push_back(IDLE);
    exp_q.push_back(model(0, 0));
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      e = exp_q.pop_front(); obs = dut_smp();
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL startup_clk%0d: got %h expected %h", k, obs, e); end
    end
  endtask

  task automatic test_frames();
    smp_t e, obs, prev;
    int trace_err = 0, fs_n = 0, fs_a = -1, fs_b = -1, von0 = 0, von1 = 0;
    int hs_first = -1, hs_run = 0, hf_a = -1, hf_b = -1, vs_low = 0, vs_edges = 0, vs_bad = 0;
    prev = IDLE;
    for (int i = 0; i <= 2 * FRAME; i++) exp_q.push_back(model(i % HT, (i / HT) % VT));
    for (int i = 0; i <= 2 * FRAME; i++) begin
      if (i > 0) @(negedge clk);
      e = exp_q.pop_front(); obs = dut_smp();
      if (obs !== e) begin
        if (trace_err < 4) $display("note: trace deviation at cycle %0d: got %h expected %h", i, obs, e);
        trace_err++;
      end
      if (obs.fs) begin
        if (fs_n == 0) fs_a = i; else if (fs_n == 1) fs_b = i;
        fs_n++;
      end
      if (obs.von && i < FRAME) von0++;
      if (obs.von && i >= FRAME && i < 2 * FRAME) von1++;
      if (i < HT && !obs.hs) begin if (hs_first < 0) hs_first = i; hs_run++; end
      if (i > 0 && prev.hs && !obs.hs) begin
        if (hf_a < 0) hf_a = i; else if (hf_b < 0) hf_b = i;
      end
      if (i < FRAME && !obs.vs) vs_low++;
      if (i > 0 && obs.vs !== prev.vs) begin vs_edges++; if (i % HT != 0) vs_bad++; end
      prev = obs;
    end
    n_cmp++; if (trace_err != 0)   begin n_err++; $display("FAIL frame_trace: %0d cycles deviated, required 0", trace_err); end
    n_cmp++; if (fs_n != 3)        begin n_err++; $display("FAIL fs_count: got %0d required 3", fs_n); end
    n_cmp++; if (fs_b - fs_a != FRAME) begin n_err++; $display("FAIL fs_period: got %0d required %0d", fs_b - fs_a, FRAME); end
    n_cmp++; if (von0 != HA * VA)  begin n_err++; $display("FAIL video_on_f0: got %0d required %0d", von0, HA * VA); end
    n_cmp++; if (von1 != HA * VA)  begin n_err++; $display("FAIL video_on_f1: got %0d required %0d", von1, HA * VA); end
    n_cmp++; if (hs_first != 656)  begin n_err++; $display("FAIL hsync_start: got %0d required 656", hs_first); end
    n_cmp++; if (hs_run != 96)     begin n_err++; $display("FAIL hsync_width: got %0d required 96", hs_run); end
    n_cmp++; if (hf_b - hf_a != HT) begin n_err++; $display("FAIL h_period: got %0d required %0d", hf_b - hf_a, HT); end
    n_cmp++; if (vs_low != 1600)   begin n_err++; $display("FAIL vsync_low: got %0d required 1600", vs_low); end
    n_cmp++; if (vs_edges != 4)    begin n_err++; $display("FAIL vsync_edges: got %0d required 4", vs_edges); end
    n_cmp++; if (vs_bad != 0)      begin n_err++; $display("FAIL vsync_edge_align: got %0d off-h0 edges required 0", vs_bad); end
  endtask

  // Starts at (0,0); drops lock at (300,5), then restores it.
  task automatic test_lock_drop();
    smp_t e, obs;
    repeat (5 * HT + 300) @(negedge clk);
    obs = dut_smp(); e = model(300, 5);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL lock_drop_pos: got %h expected %h", obs, e); end
    locked = 1'b0;
    exp_q.push_back(model(301, 5));
    exp_q.push_back(model(302, 5));
    for (int k = 0; k < 5; k++) exp_q.push_back(IDLE);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      e = exp_q.pop_front(); obs = dut_smp();
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL lock_drop[%0d]: got %h expected %h", k, obs, e); end
    end
    locked = 1'b1;
    exp_q.push_back(IDLE);
    exp_q.push_back(IDLE);
    exp_q.push_back(model(0, 0));
    exp_q.push_back(model(1, 0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e = exp_q.pop_front(); obs = dut_smp();
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL relock[%0d]: got %h expected %h", k, obs, e); end
    end
  endtask

  // Starts at (1,0); visits (0,1), (600,1), then asserts reset mid-cycle at (400,2).
  task automatic test_async_reset();
    smp_t e, obs;
    repeat (HT - 1) @(negedge clk);
    obs = dut_smp(); e = model(0, 1);
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL pos_0_1: got %h expected %h", obs, e); end
`ifdef VGA_TEST_PATTERN_EN
    n_cmp++; if (rgb !== 12'hFFF) begin n_err++; $display("FAIL rgb_x0: got %h expected FFF", rgb); end
`endif
    repeat (600) @(negedge clk);
    obs = dut_smp(); e = model(600, 1);
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL pos_600_1: got %h expected %h", obs, e); end
`ifdef VGA_TEST_PATTERN_EN
    n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL rgb_x600: got %h expected 000", rgb); end
`endif
    repeat (600) @(negedge clk);
    obs = dut_smp(); e = model(400, 2);
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL pre_reset: got %h expected %h", obs, e); end
    #5 rst = 1'b0;
    #1;
    exp_q.push_back(IDLE);
    e = exp_q.pop_front(); obs = dut_smp();
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL async_reset: got %h expected %h", obs, e); end
`ifdef VGA_TEST_PATTERN_EN
    n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL async_reset_rgb: got %h expected 000", rgb); end
`endif
    @(negedge clk);
    obs = dut_smp();
    n_cmp++; if (obs !== IDLE) begin n_err++; $display("FAIL reset_hold: got %h expected %h", obs, IDLE); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_frames();
    test_lock_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
